// File: rtl/ddram_wr_arbiter_if.sv
// DDRAM write-channel bundle shared by the arbiter and the memory port.
// The arbiter drives commands; the memory side returns DDRAM_BUSY.
interface ddram_wr_arbiter_if #(
  parameter int AW = 29
);
  logic          DDRAM_BUSY;
  logic          DDRAM_WE;
  logic [AW-1:0] DDRAM_ADDR;
  logic [63:0]   DDRAM_DIN;
  logic [7:0]    DDRAM_BE;
  logic [7:0]    DDRAM_BURSTCNT;
  logic          DDRAM_RD;

  modport master (
    input  DDRAM_BUSY,
    output DDRAM_WE,
    output DDRAM_ADDR,
    output DDRAM_DIN,
    output DDRAM_BE,
    output DDRAM_BURSTCNT,
    output DDRAM_RD
  );

  modport slave (
    output DDRAM_BUSY,
    input  DDRAM_WE,
    input  DDRAM_ADDR,
    input  DDRAM_DIN,
    input  DDRAM_BE,
    input  DDRAM_BURSTCNT,
    input  DDRAM_RD
  );
endinterface

// File: rtl/ddram_wr_arbiter.sv
// Two-port round-robin DDRAM write arbiter with per-port FIFOs.
// Define DDRAM_ARB_STATS_EN to build the saturating drop counters.
module ddram_wr_arbiter #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AW         = 29
) (
  input  logic          CLK_VIDEO,
  input  logic          reset,
  input  logic          p0_wr,
  input  logic [AW-1:0] p0_addr,
  input  logic [63:0]   p0_data,
  input  logic [7:0]    p0_be,
  output logic          p0_full,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_addr,
  input  logic [63:0]   p1_data,
  input  logic [7:0]    p1_be,
  output logic          p1_full,
  ddram_wr_arbiter_if.master ddr,
  output logic [7:0]    p0_drops,
  output logic [7:0]    p1_drops,
  output logic          idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = AW + 72;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [EW-1:0] mem [2][DEPTH];
  logic [EW-1:0] din [2];
  ptr_t          wptr [2];
  ptr_t          rptr [2];
  cnt_t          cnt  [2];

  logic [1:0]    wr;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonempty;
  logic [1:0]    at_full;

  logic [0:0]    state;
  logic          rr;
  logic          cur_port;
  logic          accept;
  logic          load;
  logic          favour;
  logic          sel;
  logic [EW-1:0] head;

  logic [AW-1:0] cmd_addr;
  logic [63:0]   cmd_data;
  logic [7:0]    cmd_be;

  assign wr     = {p1_wr, p0_wr};
  assign din[0] = {p0_addr, p0_data, p0_be};
  assign din[1] = {p1_addr, p1_data, p1_be};

  // Full is judged on the pre-pop count, so a push racing a pop
  // on a full FIFO is dropped.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (cnt[i] != '0);
      at_full[i]  = (cnt[i] == cnt_t'(DEPTH));
      push[i]     = wr[i] && !at_full[i];
    end
  end

  assign accept = (state == S_ISSUE) && !ddr.DDRAM_BUSY;
  assign load   = (|nonempty) && ((state == S_IDLE) || accept);

  // On acceptance the pointer already favours the other port.
  assign favour = (state == S_IDLE) ? rr : ~cur_port;
  assign sel    = (&nonempty) ? favour : nonempty[1];
  assign head   = mem[sel][rptr[sel]];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pop[i] = load && (sel == 1'(i));
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem[i][wptr[i]] <= din[i];
      end
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wptr[i] <= wptr[i] + ptr_t'(1);
        end
        if (pop[i]) begin
          rptr[i] <= rptr[i] + ptr_t'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + cnt_t'(1);
          2'b01:   cnt[i] <= cnt[i] - cnt_t'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state    <= S_IDLE;
      rr       <= 1'b0;
      cur_port <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_be   <= '0;
    end else begin
      if (accept) begin
        rr <= ~cur_port;
      end
      if (load) begin
        state    <= S_ISSUE;
        cur_port <= sel;
        {cmd_addr, cmd_data, cmd_be} <= head;
      end else if (accept) begin
        state <= S_IDLE;
      end
    end
  end

  assign ddr.DDRAM_WE       = (state == S_ISSUE);
  assign ddr.DDRAM_ADDR     = cmd_addr;
  assign ddr.DDRAM_DIN      = cmd_data;
  assign ddr.DDRAM_BE       = cmd_be;
  assign ddr.DDRAM_BURSTCNT = 8'd1;
  assign ddr.DDRAM_RD       = 1'b0;

  assign p0_full = at_full[0];
  assign p1_full = at_full[1];
  assign idle    = !(|nonempty) && (state == S_IDLE);

`ifdef DDRAM_ARB_STATS_EN
  logic [7:0] drops [2];

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      drops[0] <= '0;
      drops[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr[i] && at_full[i] && (drops[i] != 8'hFF)) begin
          drops[i] <= drops[i] + 8'd1;
        end
      end
    end
  end

  assign p0_drops = drops[0];
  assign p1_drops = drops[1];
`else
  assign p0_drops = 8'd0;
  assign p1_drops = 8'd0;
`endif

endmodule

// File: tb/tb_ddram_wr_arbiter.sv
// Randomized bench for ddram_wr_arbiter with a queue-based reference
// model, plus directed scenarios pinned to literal expectations.
module tb_ddram_wr_arbiter;
  localparam int AW = 29;

  logic          CLK_VIDEO = 1'b0;
  logic          reset;
  logic          p0_wr, p1_wr;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [63:0]   p0_data, p1_data;
  logic [7:0]    p0_be, p1_be;
  logic          p0_full, p1_full;
  logic [7:0]    p0_drops, p1_drops;
  logic          idle;
  logic          busy;

  ddram_wr_arbiter_if #(.AW(AW)) ddr ();
  assign ddr.DDRAM_BUSY = busy;

  ddram_wr_arbiter #(.DEPTH_LOG2(4), .AW(AW)) dut (
    .CLK_VIDEO (CLK_VIDEO),
    .reset     (reset),
    .p0_wr     (p0_wr),
    .p0_addr   (p0_addr),
    .p0_data   (p0_data),
    .p0_be     (p0_be),
    .p0_full   (p0_full),
    .p1_wr     (p1_wr),
    .p1_addr   (p1_addr),
    .p1_data   (p1_data),
    .p1_be     (p1_be),
    .p1_full   (p1_full),
    .ddr       (ddr),
    .p0_drops  (p0_drops),
    .p1_drops  (p1_drops),
    .idle      (idle)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
    logic [7:0]    b;
  } ent_t;

  ent_t          mq0 [$];
  ent_t          mq1 [$];
  ent_t          m_cmd;
  bit            m_we;
  bit            m_port;
  bit            m_rr;
  int            m_drops0, m_drops1;
  logic [AW-1:0] acc_log [$];

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  s0, s1;
    bit  go;
    bit  pick;
    if (!reset && ddr.DDRAM_WE && !busy) acc_log.push_back(ddr.DDRAM_ADDR);
    if (reset) begin
      mq0.delete();
      mq1.delete();
      m_we  = 0;
      m_rr  = 0;
      m_port = 0;
      m_cmd = '{a: '0, d: '0, b: '0};
      m_drops0 = 0;
      m_drops1 = 0;
      return;
    end
    s0 = mq0.size();
    s1 = mq1.size();
    go = 0;
    if (!m_we) begin
      go = (s0 > 0) || (s1 > 0);
    end else if (!busy) begin
      m_rr = !m_port;
      go = (s0 > 0) || (s1 > 0);
      if (!go) m_we = 0;
    end
    if (go) begin
      pick = (s0 > 0 && s1 > 0) ? m_rr : (s0 == 0);
      m_cmd = pick ? mq1.pop_front() : mq0.pop_front();
      m_port = pick;
      m_we = 1;
    end
    if (p0_wr) begin
      if (s0 == 16) begin
`ifdef DDRAM_ARB_STATS_EN
        if (m_drops0 < 255) m_drops0++;
`endif
      end else mq0.push_back('{a: p0_addr, d: p0_data, b: p0_be});
    end
    if (p1_wr) begin
      if (s1 == 16) begin
`ifdef DDRAM_ARB_STATS_EN
        if (m_drops1 < 255) m_drops1++;
`endif
      end else mq1.push_back('{a: p1_addr, d: p1_data, b: p1_be});
    end
  endtask

  initial forever begin
    @(posedge CLK_VIDEO);
    model_step();
  end

  initial forever begin
    @(negedge CLK_VIDEO);
    if (chk_en) begin
      chk("we", ddr.DDRAM_WE, m_we);
      chk("addr", ddr.DDRAM_ADDR, m_cmd.a);
      chk("din", ddr.DDRAM_DIN, m_cmd.d);
      chk("be", ddr.DDRAM_BE, m_cmd.b);
      chk("p0_full", p0_full, mq0.size() == 16);
      chk("p1_full", p1_full, mq1.size() == 16);
      chk("idle", idle, mq0.size() == 0 && mq1.size() == 0 && !m_we);
      chk("p0_drops", p0_drops, m_drops0[7:0]);
      chk("p1_drops", p1_drops, m_drops1[7:0]);
      chk("burstcnt", ddr.DDRAM_BURSTCNT, 8'd1);
      chk("rd", ddr.DDRAM_RD, 1'b0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK_VIDEO);
  endtask

  task automatic inputs_off();
    p0_wr = 0;
    p1_wr = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    inputs_off();
    tick();
    reset = 0;
  endtask

  logic [63:0] bp_data;
  int          base;
  bit          ok;

  initial begin
    reset = 1;
    busy = 0;
    inputs_off();
    p0_addr = '0; p0_data = '0; p0_be = '0;
    p1_addr = '0; p1_data = '0; p1_be = '0;
    tick(2);
    chk_en = 1;
    chk("rst_we", ddr.DDRAM_WE, 1'b0);
    chk("rst_idle", idle, 1'b1);

    // single write, fixed latency
    reset = 0;
    p0_wr = 1; p0_addr = AW'(32'h1234);
    p0_data = {8{8'hAA}}; p0_be = 8'h0F;
    tick();
    inputs_off();
    chk("lat_c1_we", ddr.DDRAM_WE, 1'b0);
    tick();
    chk("lat_c2_we", ddr.DDRAM_WE, 1'b1);
    chk("lat_c2_addr", ddr.DDRAM_ADDR, 64'h1234);
    chk("lat_c2_din", ddr.DDRAM_DIN, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("lat_c2_be", ddr.DDRAM_BE, 8'h0F);
    tick();
    chk("lat_c3_we", ddr.DDRAM_WE, 1'b0);
    chk("lat_c3_idle", idle, 1'b1);

    // back-pressure for 10 cycles
    busy = 1;
    bp_data = {$urandom, $urandom};
    p0_wr = 1; p0_addr = AW'(32'h2000); p0_data = bp_data; p0_be = 8'hF0;
    tick();
    inputs_off();
    tick();
    base = acc_log.size();
    for (int i = 0; i < 10; i++) begin
      chk("bp_we", ddr.DDRAM_WE, 1'b1);
      chk("bp_addr", ddr.DDRAM_ADDR, 64'h2000);
      chk("bp_din", ddr.DDRAM_DIN, bp_data);
      chk("bp_be", ddr.DDRAM_BE, 8'hF0);
      tick();
    end
    chk("bp_none_yet", acc_log.size() - base, 0);
    busy = 0;
    tick(3);
    chk("bp_one_accept", acc_log.size() - base, 1);

    // fairness from a fresh reset
    do_reset();
    busy = 1;
    for (int i = 0; i < 4; i++) begin
      p0_wr = 1; p0_addr = AW'(32'h100 + i);
      p1_wr = 1; p1_addr = AW'(32'h200 + i);
      tick();
    end
    inputs_off();
    base = acc_log.size();
    busy = 0;
    tick(12);
    chk("fair_count", acc_log.size() - base, 8);
    ok = (acc_log.size() - base == 8);
    for (int k = 0; k < 8 && ok; k++) begin
      if (acc_log[base + k] !== AW'(((k % 2) ? 32'h200 : 32'h100) + k / 2))
        ok = 0;
    end
    chk("fair_order", ok, 1'b1);

    // overflow on port 1 while the command is stalled
    do_reset();
    busy = 1;
    p0_wr = 1; p0_addr = AW'(32'h500);
    tick();
    inputs_off();
    tick(2);
    for (int i = 0; i < 20; i++) begin
      p1_wr = 1; p1_addr = AW'(32'h300 + i);
      tick();
    end
    inputs_off();
    tick();
    chk("ovf_full", p1_full, 1'b1);
`ifdef DDRAM_ARB_STATS_EN
    chk("ovf_drops", p1_drops, 8'd4);
`else
    chk("ovf_drops", p1_drops, 8'd0);
`endif
    base = acc_log.size();
    busy = 0;
    tick(25);
    ok = (acc_log.size() - base == 17) && (acc_log[base] === AW'(32'h500));
    for (int k = 0; k < 16 && ok; k++) begin
      if (acc_log[base + 1 + k] !== AW'(32'h300 + k)) ok = 0;
    end
    chk("ovf_written", ok, 1'b1);

    // push into a full FIFO on the same cycle as its pop
    do_reset();
    busy = 1;
    p1_wr = 1; p1_addr = AW'(32'h600);
    tick();
    inputs_off();
    tick(2);
    for (int i = 0; i < 16; i++) begin
      p0_wr = 1; p0_addr = AW'(32'h700 + i);
      tick();
    end
    chk("fp_full", p0_full, 1'b1);
    busy = 0;
    p0_wr = 1; p0_addr = AW'(32'hDEAD);
    tick();
    inputs_off();
    busy = 1;
    chk("fp_not_full", p0_full, 1'b0);
    chk("fp_head", ddr.DDRAM_ADDR, 64'h700);
`ifdef DDRAM_ARB_STATS_EN
    chk("fp_drops", p0_drops, 8'd1);
`else
    chk("fp_drops", p0_drops, 8'd0);
`endif
    base = acc_log.size();
    busy = 0;
    tick(20);
    ok = (acc_log.size() - base == 16);
    for (int k = 0; k < 16 && ok; k++) begin
      if (acc_log[base + k] !== AW'(32'h700 + k)) ok = 0;
    end
    chk("fp_remaining", ok, 1'b1);

    // reset while a command is stalled
    busy = 1;
    p0_wr = 1; p0_addr = AW'(32'h800);
    p1_wr = 1; p1_addr = AW'(32'h900);
    tick();
    inputs_off();
    tick(2);
    chk("rmi_we_before", ddr.DDRAM_WE, 1'b1);
    reset = 1;
    tick();
    reset = 0;
    chk("rmi_we_after", ddr.DDRAM_WE, 1'b0);
    chk("rmi_idle", idle, 1'b1);
    base = acc_log.size();
    busy = 0;
    p0_wr = 1; p0_addr = AW'(32'hA00);
    p1_wr = 1; p1_addr = AW'(32'hB00);
    tick();
    inputs_off();
    tick(5);
    chk("rmi_count", acc_log.size() - base, 2);
    chk("rmi_first", (acc_log.size() > base) ? acc_log[base] : '1, 64'hA00);

    // randomized traffic against the model
    for (int w = 0; w < 20; w++) begin
      int bp = $urandom_range(0, 9);
      int r0 = $urandom_range(1, 9);
      int r1 = $urandom_range(1, 9);
      for (int c = 0; c < 150; c++) begin
        reset = ($urandom_range(0, 599) == 0);
        busy  = ($urandom_range(0, 9) < bp);
        p0_wr = ($urandom_range(0, 9) < r0);
        p1_wr = ($urandom_range(0, 9) < r1);
        p0_addr = AW'($urandom); p0_data = {$urandom, $urandom};
        p0_be = 8'($urandom);
        p1_addr = AW'($urandom); p1_data = {$urandom, $urandom};
        p1_be = 8'($urandom);
        tick();
      end
    end
    reset = 0;
    busy = 0;
    inputs_off();
    tick(40);
    chk("final_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
